// File: rtl/sync_arith_unit_29_pkg.sv
// Shared opcode and status-bit definitions for the sync_arith_unit_29 ALU slice.
package sync_arith_unit_29_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOT  = 4'd5,
        OP_SHL  = 4'd6,
        OP_SHR  = 4'd7,
        OP_SRA  = 4'd8,
        OP_SLT  = 4'd9,
        OP_NEG  = 4'd10,
        OP_MUL  = 4'd11,
        OP_INC  = 4'd12,
        OP_DEC  = 4'd13,
        OP_ABS  = 4'd14,
        OP_RSVD = 4'd15
    } op_e;

    localparam int ST_ERR  = 3;
    localparam int ST_OVF  = 2;
    localparam int ST_ZERO = 1;
    localparam int ST_NEG  = 0;

endpackage

// File: rtl/sync_arith_unit_29_core.sv
// arith_core_29: purely combinational result and flag generation for one operation.
module arith_core_29
    import sync_arith_unit_29_pkg::*;
#(
    parameter int M = 32
) (
    input  logic [M-1:0] i_a,
    input  logic [M-1:0] i_b,
    input  logic [3:0]   i_op,
    output logic [M-1:0] o_result,
    output logic [3:0]   o_status
);

    localparam logic [M-1:0] LP_MIN = {1'b1, {(M-1){1'b0}}};
    localparam logic [M-1:0] LP_MAX = {1'b0, {(M-1){1'b1}}};
    localparam logic [M-1:0] LP_ONE = {{(M-1){1'b0}}, 1'b1};

    // Two's complement add overflows when both operands share a sign the sum lacks.
    function automatic logic ovf_add(input logic sa, input logic sb, input logic ss);
        return (sa == sb) && (ss != sa);
    endfunction

    function automatic logic ovf_sub(input logic sa, input logic sb, input logic ss);
        return (sa != sb) && (ss != sa);
    endfunction

    logic signed [M-1:0]   w_a_s;
    logic signed [M-1:0]   w_b_s;
    logic [M-1:0]          w_sum;
    logic [M-1:0]          w_diff;
    logic signed [2*M-1:0] w_prod;
    logic [M:0]            w_prod_hi;
    logic [M-1:0]          w_sra;
    logic                  w_big_shift;
    logic                  w_a_min;
    logic [M-1:0]          w_res;
    logic                  w_ovf;
    op_e                   w_op;

    assign w_op        = op_e'(i_op);
    assign w_a_s       = i_a;
    assign w_b_s       = i_b;
    assign w_sum       = i_a + i_b;
    assign w_diff      = i_a - i_b;
    assign w_prod      = $signed({{M{i_a[M-1]}}, i_a}) * $signed({{M{i_b[M-1]}}, i_b});
    assign w_prod_hi   = w_prod[2*M-1:M-1];
    assign w_sra       = w_a_s >>> i_b;
    assign w_big_shift = (i_b >= M[M-1:0]);
    assign w_a_min     = (i_a == LP_MIN);

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_res = w_sum;
                w_ovf = ovf_add(i_a[M-1], i_b[M-1], w_sum[M-1]);
            end
            OP_SUB: begin
                w_res = w_diff;
                w_ovf = ovf_sub(i_a[M-1], i_b[M-1], w_diff[M-1]);
            end
            OP_AND: w_res = i_a & i_b;
            OP_OR:  w_res = i_a | i_b;
            OP_XOR: w_res = i_a ^ i_b;
            OP_NOT: w_res = ~i_a;
            OP_SHL: w_res = w_big_shift ? '0 : (i_a << i_b);
            OP_SHR: w_res = w_big_shift ? '0 : (i_a >> i_b);
            OP_SRA: w_res = w_big_shift ? {M{i_a[M-1]}} : w_sra;
            OP_SLT: w_res = (w_a_s < w_b_s) ? LP_ONE : '0;
            OP_NEG: begin
                w_res = -i_a;
                w_ovf = w_a_min;
            end
            OP_MUL: begin
                // Product fits only if the top M+1 bits are a pure sign extension.
                w_res = w_prod[M-1:0];
                w_ovf = !((&w_prod_hi) || (~|w_prod_hi));
            end
            OP_INC: begin
                w_res = i_a + LP_ONE;
                w_ovf = (i_a == LP_MAX);
            end
            OP_DEC: begin
                w_res = i_a - LP_ONE;
                w_ovf = w_a_min;
            end
            OP_ABS: begin
                w_res = i_a[M-1] ? -i_a : i_a;
                w_ovf = w_a_min;
            end
            default: begin
                w_res = '0;
                w_ovf = 1'b0;
            end
        endcase
    end

    always_comb begin
        o_result = w_res;
        o_status = '0;
        if (w_op == OP_RSVD) begin
            o_status[ST_ERR] = 1'b1;
        end else begin
            o_status[ST_OVF]  = w_ovf;
            o_status[ST_ZERO] = (w_res == '0);
            o_status[ST_NEG]  = w_res[M-1];
        end
    end

endmodule

// File: rtl/sync_arith_unit_29.sv
// sync_arith_unit_29: one-cycle registered ALU; the core result is captured every clock.
module sync_arith_unit_29
    import sync_arith_unit_29_pkg::*;
#(
    parameter int M = 32
) (
    input  logic         clk,
    input  logic         i_reset,
    input  logic [M-1:0] iarg_A,
    input  logic [M-1:0] iarg_B,
    input  logic [3:0]   iop,
    output logic [M-1:0] o_result,
    output logic [3:0]   o_status
);

    logic [M-1:0] w_result;
    logic [3:0]   w_status;
    logic [M-1:0] r_result;
    logic [3:0]   r_status;

    arith_core_29 #(.M(M)) u_core (
        .i_a      (iarg_A),
        .i_b      (iarg_B),
        .i_op     (iop),
        .o_result (w_result),
        .o_status (w_status)
    );

    // Output register stage: reset clears outputs immediately, independent of clk.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            r_result <= '0;
            r_status <= '0;
        end else begin
            r_result <= w_result;
            r_status <= w_status;
        end
    end

    assign o_result = r_result;
    assign o_status = r_status;

endmodule

// File: tb/tb_sync_arith_unit_29.sv
// Self-checking bench for sync_arith_unit_29 (M=32): directed corner cases plus random ops vs. a reference model.
module tb_sync_arith_unit_29;

    localparam int M = 32;

    logic          clk;
    logic          i_reset;
    logic [M-1:0]  iarg_A;
    logic [M-1:0]  iarg_B;
    logic [3:0]    iop;
    logic [M-1:0]  o_result;
    logic [3:0]    o_status;

    int checks = 0;
    int errors = 0;

    sync_arith_unit_29 #(.M(M)) dut (
        .clk      (clk),
        .i_reset  (i_reset),
        .iarg_A   (iarg_A),
        .iarg_B   (iarg_B),
        .iop      (iop),
        .o_result (o_result),
        .o_status (o_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: full-precision integer arithmetic, overflow judged by range.
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
        longint sa;
        longint sb;
        longint r;
        logic [31:0] res;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        r   = 0;
        res = 32'd0;
        ovf = 1'b0;
        if (op == 4'd15) return {4'b1000, 32'd0};
        case (op)
            4'd0:  r = sa + sb;
            4'd1:  r = sa - sb;
            4'd10: r = -sa;
            4'd11: r = sa * sb;
            4'd12: r = sa + 1;
            4'd13: r = sa - 1;
            4'd14: r = (sa < 0) ? -sa : sa;
            default: r = 0;
        endcase
        case (op)
            4'd0, 4'd1, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14: begin
                res = r[31:0];
                ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            4'd2: res = a & b;
            4'd3: res = a | b;
            4'd4: res = a ^ b;
            4'd5: res = ~a;
            4'd6: res = (b >= 32) ? 32'd0 : (a << b);
            4'd7: res = (b >= 32) ? 32'd0 : (a >> b);
            4'd8: begin
                r   = sa >>> ((b >= 32) ? 32'd63 : b);
                res = r[31:0];
            end
            4'd9: res = (sa < sb) ? 32'd1 : 32'd0;
            default: res = 32'd0;
        endcase
        return {1'b0, ovf, (res == 32'd0), res[31], res};
    endfunction

    task automatic check(input string tag, input logic [31:0] er, input logic [3:0] es);
        checks++;
        assert (o_result === er) else begin
            errors++;
            $error("FAIL %s result observed=%h expected=%h", tag, o_result, er);
        end
        checks++;
        assert (o_status === es) else begin
            errors++;
            $error("FAIL %s status observed=%b expected=%b", tag, o_status, es);
        end
    endtask

    // Present inputs on the falling edge, then sample just after the next rising edge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        @(negedge clk);
        iarg_A = a;
        iarg_B = b;
        iop    = op;
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] op, input logic [31:0] er, input logic [3:0] es);
        run_op(a, b, op);
        check(tag, er, es);
    endtask

    initial begin
        logic [35:0] exp_v;
        logic [35:0] prev_v;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;

        i_reset = 1'b0;
        iarg_A  = 32'd0;
        iarg_B  = 32'd0;
        iop     = 4'd0;
        #1;
        check("reset_initial", 32'd0, 4'b0000);

        // Outputs stay cleared across edges while reset is held, even with live inputs.
        iarg_A = 32'd9;
        iarg_B = 32'd9;
        iop    = 4'd0;
        @(posedge clk);
        #1;
        check("reset_held", 32'd0, 4'b0000);

        @(negedge clk);
        i_reset = 1'b1;
        directed("add_first", 32'd3, 32'd4, 4'd0, 32'd7, 4'b0000);
        directed("sub_neg", 32'd2, 32'd5, 4'd1, 32'hFFFFFFFD, 4'b0001);

        // Asynchronous reset mid-cycle after a non-zero result.
        #2;
        i_reset = 1'b0;
        #1;
        check("reset_async", 32'd0, 4'b0000);
        @(negedge clk);
        i_reset = 1'b1;
        directed("add_after_rst", 32'd3, 32'd4, 4'd0, 32'd7, 4'b0000);

        directed("add_ovf", 32'h7FFFFFFF, 32'd1, 4'd0, 32'h80000000, 4'b0101);
        directed("sub_zero", 32'd5, 32'd5, 4'd1, 32'd0, 4'b0010);
        directed("mul_ovf", 32'h00010000, 32'h00010000, 4'd11, 32'd0, 4'b0110);
        directed("mul_neg", 32'hFFFFFFFD, 32'd7, 4'd11, 32'hFFFFFFEB, 4'b0001);
        directed("neg_min", 32'h80000000, 32'd0, 4'd10, 32'h80000000, 4'b0101);
        directed("abs_m7", 32'hFFFFFFF9, 32'd0, 4'd14, 32'd7, 4'b0000);
        directed("abs_min", 32'h80000000, 32'd0, 4'd14, 32'h80000000, 4'b0101);
        directed("inc_max", 32'h7FFFFFFF, 32'd0, 4'd12, 32'h80000000, 4'b0101);
        directed("dec_min", 32'h80000000, 32'd0, 4'd13, 32'h7FFFFFFF, 4'b0100);
        directed("shl_31", 32'd1, 32'd31, 4'd6, 32'h80000000, 4'b0001);
        directed("shl_32", 32'd1, 32'd32, 4'd6, 32'd0, 4'b0010);
        directed("shr_40", 32'hFFFFFFFF, 32'd40, 4'd7, 32'd0, 4'b0010);
        directed("sra_40", 32'h80000000, 32'd40, 4'd8, 32'hFFFFFFFF, 4'b0001);
        directed("sra_4", 32'h80000000, 32'd4, 4'd8, 32'hF8000000, 4'b0001);
        directed("slt_m1_1", 32'hFFFFFFFF, 32'd1, 4'd9, 32'd1, 4'b0000);
        directed("slt_1_m1", 32'd1, 32'hFFFFFFFF, 4'd9, 32'd0, 4'b0010);
        directed("rsvd", 32'h12345678, 32'h9, 4'd15, 32'd0, 4'b1000);
        directed("not_zero", 32'hFFFFFFFF, 32'd0, 4'd5, 32'd0, 4'b0010);

        // Back-to-back random ops; also verify the output holds until the next edge.
        prev_v = {4'b0010, 32'd0};
        for (int i = 0; i < 300; i++) begin
            a  = $urandom;
            b  = $urandom;
            op = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 5))
                0: b = 32'($urandom_range(0, 40));
                1: a = 32'h80000000;
                2: a = 32'h7FFFFFFF;
                3: begin
                    a = 32'($signed(16'($urandom)));
                    b = 32'($signed(16'($urandom)));
                end
                default: ;
            endcase
            @(negedge clk);
            iarg_A = a;
            iarg_B = b;
            iop    = op;
            #1;
            check($sformatf("hold_%0d", i), prev_v[31:0], prev_v[35:32]);
            exp_v = model(a, b, op);
            @(posedge clk);
            #1;
            check($sformatf("rand_%0d_op%0d", i, op), exp_v[31:0], exp_v[35:32]);
            prev_v = exp_v;
        end

        // Reset mid-stream leaves no residue.
        #2;
        i_reset = 1'b0;
        #1;
        check("reset_midstream", 32'd0, 4'b0000);
        @(negedge clk);
        i_reset = 1'b1;
        directed("xor_after_rst", 32'hF0F0F0F0, 32'h0FF00FF0, 4'd4, 32'hFF00FF00, 4'b0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sync_arith_unit_29.md
SYNC_ARITH_UNIT_29 -- requirements
Module: sync_arith_unit_29

Interface
REQ-001 The block SHALL have parameter M, default 32, giving the operand/result width in bits; legal values are M >= 4.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port i_reset, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port iarg_A, input, M bits, operand A, two's complement.
REQ-005 The block SHALL have port iarg_B, input, M bits, operand B, two's complement.
REQ-006 The block SHALL have port iop, input, 4 bits, operation select.
REQ-007 The block SHALL have port o_result, output, M bits, registered result.
REQ-008 The block SHALL have port o_status, output, 4 bits, registered flags: [3]=error, [2]=overflow, [1]=zero, [0]=negative.

Function
REQ-009 On each rising clk with i_reset high, the block SHALL sample iarg_A, iarg_B and iop, and SHALL register o_result/o_status: 1-cycle latency, no handshake, a new operation every cycle.
REQ-010 Opcode map SHALL be:
- 0 ADD A+B.
- 1 SUB A-B.
- 2 AND.
- 3 OR.
- 4 XOR.
- 5 NOT A.
- 6 SHL A by B.
- 7 SHR (logical) A by B.
- 8 SRA A by B.
- 9 SLT: result 1 if A<B signed, else 0.
- 10 NEG: -A.
- 11 MUL: low M bits of signed A*B.
- 12 INC: A+1.
- 13 DEC: A-1.
- 14 ABS of A.
- 15 reserved.
REQ-011 Overflow SHALL be set as follows:
- ADD/SUB/INC/DEC: on signed overflow.
- NEG/ABS: when A is the most negative value; the result is then that value unchanged.
- MUL: when the full signed product does not fit in M bits.
- All other opcodes: overflow = 0.
REQ-012 For shift opcodes, if unsigned B >= M, SHL/SHR SHALL give 0 and SRA SHALL give all bits equal to A[M-1].
REQ-013 Zero SHALL equal (result == 0), and negative SHALL equal result[M-1], for every valid opcode.
REQ-014 For opcode 15, the block SHALL set o_result=0 and o_status=4'b1000; the zero/negative/overflow flags are not set in this case.
REQ-015 The error flag SHALL be 0 for all opcodes 0-14.
REQ-016 Outputs SHALL hold their last value only between clock edges; there is no enable, and every edge with reset inactive loads a new result.

Reset
REQ-017 When i_reset goes low, o_result SHALL become 0 and o_status SHALL become 4'b0000 immediately, without waiting for clk.
REQ-018 While i_reset is low, outputs SHALL stay 0 regardless of clk and inputs.
REQ-019 After i_reset is released, the first rising clk SHALL load the operation presented at that edge.
REQ-020 Reset asserted mid-stream SHALL discard the in-flight result with no residual state.

Structure
REQ-021 A shared package SHALL hold:
- the 4-bit opcode enum (OP_ADD..OP_RSVD);
- status bit index constants (ST_ERR=3, ST_OVF=2, ST_ZERO=1, ST_NEG=0).
REQ-022 A combinational sub-module arith_core_29 SHALL compute result and flags from A, B and op.
REQ-023 sync_arith_unit_29 SHALL contain only the arith_core_29 instance and the async-reset output registers.

Verification
REQ-024 Reset: drive i_reset=0 mid-cycle after non-zero results -> o_result=0 and o_status=0 before the next clk edge; release, then ADD 3+4 -> 7, status 0000 one edge later.
REQ-025 Add overflow (M=32): ADD 0x7FFFFFFF+1 -> 0x80000000, status 0101; SUB 5-5 -> 0, status 0010.
REQ-026 MUL/NEG edges: MUL 0x10000*0x10000 -> 0, status 0110; NEG 0x80000000 -> 0x80000000, status 0101; ABS -7 -> 7, status 0000.
REQ-027 Shifts and compare:
- SHL 1 by 31 -> 0x80000000, status 0001.
- SHR by 40 -> 0, status 0010.
- SRA 0x80000000 by 40 -> 0xFFFFFFFF, status 0001.
- SLT -1,1 -> 1.
REQ-028 Reserved opcode: iop=15 -> o_result 0, status 1000; back-to-back opcodes on consecutive cycles each produce their result exactly one edge later.
